// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle instruction controller.
//   - state_t      : FSM state encodings (visible on the state output)
//   - OP_*         : opcode constants, held 6 bits wide (the widest legal OP_W)
//   - ALU_*        : alu_op codes driven to the datapath
//   - op_is_legal  : opcode legality check for a given opcode width
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_SW   = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ADDI only has an encoding once the opcode field is at least 3 bits wide.
  function automatic logic op_is_legal(input logic [5:0] op_v, input int op_w);
    logic legal_v;
    if (op_v < 6'd4) begin
      legal_v = 1'b1;
    end else if ((op_w >= 32'sd3) && (op_v == OP_ADDI)) begin
      legal_v = 1'b1;
    end else begin
      legal_v = 1'b0;
    end
    return legal_v;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational strobe decoder for multicycle_control.
// Ports:
//   state_i      current FSM state
//   op_q_i       opcode latched in DECODE
//   zero_i       ALU zero flag (BEQ taken in EXEC)
//   mem_ready_i  memory handshake (ir_write/pc_write in FETCH)
//   *_o          datapath control strobes
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 2
) (
  input  logic [2:0]      state_i,
  input  logic [OP_W-1:0] op_q_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            reg_dst_o,
  output logic            reg_write_o,
  output logic            alu_src_o,
  output logic            branch_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic [1:0]      alu_op_o,
  output logic            ir_write_o,
  output logic            pc_write_o
);

  logic [5:0] op_ext_s;
  assign op_ext_s = 6'(op_q_i);

  // Strobe decode from (state, latched opcode); only FETCH and BEQ-EXEC look at inputs.
  always_comb begin
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    branch_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = ALU_ADD;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    case (state_i)
      ST_FETCH: begin
        mem_read_o = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
      end
      ST_EXEC: begin
        case (op_ext_s)
          OP_R: begin
            alu_op_o = ALU_FUNCT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            alu_src_o = 1'b1;
            alu_op_o  = ALU_ADD;
          end
          OP_BEQ: begin
            alu_op_o   = ALU_SUB;
            branch_o   = 1'b1;
            pc_write_o = zero_i;
          end
          default: begin
            alu_op_o = ALU_ADD;
          end
        endcase
      end
      ST_MEM: begin
        if (op_ext_s == OP_LW) begin
          mem_read_o = 1'b1;
        end else if (op_ext_s == OP_SW) begin
          mem_write_o = 1'b1;
        end else begin
          mem_read_o = 1'b0;
        end
      end
      ST_WB: begin
        reg_write_o = 1'b1;
        if (op_ext_s == OP_R) begin
          reg_dst_o = 1'b1;
        end else if (op_ext_s == OP_LW) begin
          mem_to_reg_o = 1'b1;
        end else begin
          reg_dst_o = 1'b0;
        end
      end
      default: begin
        reg_dst_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Holds the state register, latched opcode, memory watchdog and retire counter;
// strobes come from ctrl_decode.
// Parameters: OP_W (opcode width 2..6), MEM_TIMEOUT (watchdog limit, >=1).
// Ports:
//   clk, reset (async, active-high), start, op, zero, mem_ready   inputs
//   reg_dst .. mem_to_reg, alu_op, ir_write, pc_write              datapath strobes
//   busy, illegal (pulse), timeout (pulse), state, instr_count     status
// Build option: define CTRL_PERF_CNT_EN to implement the 32-bit wrapping
// retired-instruction counter; otherwise instr_count is constant 0.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic [1:0]      alu_op,
  output logic            ir_write,
  output logic            pc_write,
  output logic            busy,
  output logic            illegal,
  output logic            timeout,
  output logic [2:0]      state,
  output logic [31:0]     instr_count
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  // Abort fires on the cycle the count would reach MEM_TIMEOUT, so a wait of
  // exactly MEM_TIMEOUT cycles with mem_ready low times out.
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT - 1);

  state_t          state_q;
  logic [OP_W-1:0] op_q;
  logic [WD_W-1:0] wdog_q;
  logic            illegal_q;
  logic            timeout_q;
  logic [5:0]      op_ext_s;
  state_t          end_state_s;

  assign op_ext_s    = 6'(op_q);
  // Retire: chain straight into the next FETCH when start is held.
  assign end_state_s = start ? ST_FETCH : ST_IDLE;

  // Instruction sequencer: state, opcode latch, watchdog and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      wdog_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wdog_q <= '0;
          if (start) begin
            state_q <= ST_FETCH;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (wdog_q == WD_LIMIT) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_DECODE: begin
          op_q <= op;
          if (op_is_legal(6'(op), OP_W)) begin
            state_q <= ST_EXEC;
          end else begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          wdog_q <= '0;
          case (op_ext_s)
            OP_R, OP_ADDI: state_q <= ST_WB;
            OP_LW, OP_SW:  state_q <= ST_MEM;
            OP_BEQ:        state_q <= end_state_s;
            default:       state_q <= ST_IDLE;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            wdog_q <= '0;
            if (op_ext_s == OP_LW) begin
              state_q <= ST_WB;
            end else begin
              state_q <= end_state_s;
            end
          end else if (wdog_q == WD_LIMIT) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_WB: begin
          wdog_q  <= '0;
          state_q <= end_state_s;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ctrl_decode #(
    .OP_W(OP_W)
  ) u_decode (
    .state_i     (state_q),
    .op_q_i      (op_q),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .reg_dst_o   (reg_dst),
    .reg_write_o (reg_write),
    .alu_src_o   (alu_src),
    .branch_o    (branch),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_to_reg_o(mem_to_reg),
    .alu_op_o    (alu_op),
    .ir_write_o  (ir_write),
    .pc_write_o  (pc_write)
  );

  assign busy    = (state_q != ST_IDLE);
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic        retire_s;
  logic [31:0] count_q;

  // Retire points: BEQ leaving EXEC, SW completing MEM, any WB.
  always_comb begin
    retire_s = 1'b0;
    case (state_q)
      ST_EXEC: retire_s = (op_ext_s == OP_BEQ);
      ST_MEM:  retire_s = (op_ext_s == OP_SW) && mem_ready;
      ST_WB:   retire_s = 1'b1;
      default: retire_s = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (retire_s) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (OP_W=3, MEM_TIMEOUT=15).
// The reference model describes each instruction as the list of phases it walks
// through plus the strobes each phase must show.
module tb_multicycle_control;

  localparam int OPW = 3;
  localparam int TMO = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [OPW-1:0] op;
  logic           zero;
  logic           mem_ready;
  logic           reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg;
  logic [1:0]     alu_op;
  logic           ir_write, pc_write, busy, illegal, timeout;
  logic [2:0]     state;
  logic [31:0]    instr_count;
  logic [11:0]    obs_v;

  int n_assert  = 0;
  int n_fail    = 0;
  int exp_count = 0;
  bit pend_ill  = 1'b0;
  bit pend_to   = 1'b0;
  bit in_fetch  = 1'b0;

  multicycle_control #(.OP_W(OPW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .zero(zero), .mem_ready(mem_ready),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src), .branch(branch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .ir_write(ir_write), .pc_write(pc_write), .busy(busy), .illegal(illegal),
    .timeout(timeout), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs_v = {reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg,
                  alu_op, ir_write, pc_write, busy};

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [OPW-1:0] rop();
    return OPW'($urandom_range(7, 0));
  endfunction

  function automatic int count_view();
`ifdef CTRL_PERF_CNT_EN
    return exp_count;
`else
    return 0;
`endif
  endfunction

  // Phases: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 writeback.
  function automatic logic [11:0] exp_vec(input int ph, input int opc, input logic r, input logic z);
    logic rd, rw, as, br, mr, mw, mtr, irw, pcw, bz;
    logic [1:0] ao;
    rd = 1'b0; rw = 1'b0; as = 1'b0; br = 1'b0; mr = 1'b0; mw = 1'b0; mtr = 1'b0;
    irw = 1'b0; pcw = 1'b0; ao = 2'b00;
    bz = (ph != 0);
    if (ph == 1) begin
      mr = 1'b1; irw = r; pcw = r;
    end
    if (ph == 3) begin
      if (opc == 0) ao = 2'b10;
      if (opc == 1 || opc == 2 || opc == 4) as = 1'b1;
      if (opc == 3) begin ao = 2'b01; br = 1'b1; pcw = z; end
    end
    if (ph == 4) begin
      mr = (opc == 1);
      mw = (opc == 2);
    end
    if (ph == 5) begin
      rw = 1'b1; rd = (opc == 0); mtr = (opc == 1);
    end
    return {rd, rw, as, br, mr, mw, mtr, ao, irw, pcw, bz};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ph, input int opc, input logic r, input logic z);
    check({tag, ":state"},   32'(state),   32'(ph));
    check({tag, ":strobes"}, 32'(obs_v),   32'(exp_vec(ph, opc, r, z)));
    check({tag, ":illegal"}, 32'(illegal), 32'(pend_ill));
    check({tag, ":timeout"}, 32'(timeout), 32'(pend_to));
    check({tag, ":count"},   instr_count,  32'(count_view()));
  endtask

  // One clock: drive inputs after the falling edge, check before the next rising edge.
  task automatic cyc(input int ph, input int opc, input logic s, input logic r, input logic z,
                     input logic [OPW-1:0] o, input string tag);
    @(negedge clk);
    start = s; mem_ready = r; zero = z; op = o;
    #1;
    check_all(tag, ph, opc, r, z);
    pend_ill = 1'b0;
    pend_to  = 1'b0;
  endtask

  task automatic retire(input logic s_after);
    exp_count++;
    in_fetch = s_after;
  endtask

  // Runs one instruction: fw / mw are wait cycles before mem_ready in FETCH / MEM.
  task automatic do_instr(input int opc, input logic z, input int fw, input int mw, input logic s_after);
    logic [OPW-1:0] opv;
    opv = OPW'(opc);
    if (!in_fetch) cyc(0, opc, 1'b1, rb(), rb(), rop(), "idle");
    for (int i = 0; i < fw && i < TMO; i++) cyc(1, opc, rb(), 1'b0, rb(), rop(), "fetch_wait");
    if (fw >= TMO) begin
      pend_to = 1'b1; in_fetch = 1'b0;
      return;
    end
    cyc(1, opc, rb(), 1'b1, rb(), rop(), "fetch_rdy");
    cyc(2, opc, rb(), rb(), rb(), opv, "decode");
    if (!(opc < 4 || (opc == 4 && OPW >= 3))) begin
      pend_ill = 1'b1; in_fetch = 1'b0;
      return;
    end
    if (opc == 3) begin
      cyc(3, opc, s_after, rb(), z, rop(), "exec_beq");
      retire(s_after);
      return;
    end
    cyc(3, opc, rb(), rb(), rb(), rop(), "exec");
    if (opc == 1 || opc == 2) begin
      for (int i = 0; i < mw && i < TMO; i++) cyc(4, opc, rb(), 1'b0, rb(), rop(), "mem_wait");
      if (mw >= TMO) begin
        pend_to = 1'b1; in_fetch = 1'b0;
        return;
      end
      if (opc == 2) begin
        cyc(4, opc, s_after, 1'b1, rb(), rop(), "mem_sw");
        retire(s_after);
        return;
      end
      cyc(4, opc, rb(), 1'b1, rb(), rop(), "mem_lw");
    end
    cyc(5, opc, s_after, rb(), rb(), rop(), "wb");
    retire(s_after);
  endtask

  initial begin
    int opc, fw, mw;
    reset = 1'b1; start = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check_all("reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back LW then R-type, zero wait states.
    do_instr(1, 1'b0, 0, 0, 1'b1);
    do_instr(0, 1'b0, 0, 0, 1'b0);
    // BEQ taken and not taken.
    do_instr(3, 1'b1, 0, 0, 1'b1);
    do_instr(3, 1'b0, 0, 0, 1'b0);
    // SW with three wait states in MEM.
    do_instr(2, 1'b0, 1, 3, 1'b0);
    // FETCH watchdog abort, then mem_ready on the final allowed cycle.
    do_instr(0, 1'b0, TMO, 0, 1'b0);
    do_instr(0, 1'b0, TMO - 1, 0, 1'b0);
    // MEM watchdog abort on LW.
    do_instr(1, 1'b0, 0, TMO, 1'b0);
    // ADDI and illegal opcodes.
    do_instr(4, 1'b0, 0, 0, 1'b1);
    do_instr(5, 1'b0, 0, 0, 1'b0);
    do_instr(7, 1'b0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of an LW memory wait.
    if (!in_fetch) cyc(0, 1, 1'b1, 1'b0, 1'b0, rop(), "idle");
    cyc(1, 1, 1'b0, 1'b1, 1'b0, rop(), "fetch_rdy");
    cyc(2, 1, 1'b0, 1'b0, 1'b0, OPW'(1), "decode");
    cyc(3, 1, 1'b0, 1'b0, 1'b0, rop(), "exec");
    cyc(4, 1, 1'b0, 1'b0, 1'b0, rop(), "mem_lw_wait");
    reset = 1'b1;
    exp_count = 0; in_fetch = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1'b0, rb(), rb(), rop(), "post_reset_idle");

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      opc = int'($urandom_range(7, 0));
      fw  = ($urandom_range(9, 0) == 0) ? TMO : int'($urandom_range(3, 0));
      mw  = ($urandom_range(9, 0) == 0) ? TMO : int'($urandom_range(3, 0));
      do_instr(opc, rb(), fw, mw, rb());
    end
    if (in_fetch || pend_ill || pend_to) begin
      if (in_fetch) cyc(1, 0, 1'b0, 1'b0, 1'b0, rop(), "final_fetch");
      else cyc(0, 0, 1'b0, 1'b0, 1'b0, rop(), "final_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
